id_ex_stage: RTL

//  Decode-side pipeline stage between the register file and EX. Presents rs/rt to the register file.

---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/id_ex_stage_hazard_detector.sv | 44 ++++
 rtl/id_ex_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: default widths, control-word bit indices, FSM encoding.
package id_ex_stage_pkg;

    localparam int DEF_PROC_BITS      = 32;
    localparam int DEF_REG_ADDRS_BITS = 5;
    localparam int DEF_CTRL_BITS      = 12;

    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_USES_RT   = 1;
    localparam int CTRL_IMM_ZEXT  = 2;
    localparam int CTRL_REG_WRITE = 3;

    typedef enum logic {
        ID_RUN   = 1'b0,
        ID_STALL = 1'b1
    } id_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage, grouped as one bus.
interface id_ex_stage_if #(
    parameter int PROC_BITS      = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int CTRL_BITS      = 12
);
    logic                      i_enable;
    logic                      i_valid;
    logic [31:0]               i_instruction;
    logic [31:0]               i_pc_next;
    logic [CTRL_BITS-1:0]      i_ctrl;
    logic [PROC_BITS-1:0]      i_read_data_1;
    logic [PROC_BITS-1:0]      i_read_data_2;
    logic                      i_flush;
    logic [REG_ADDRS_BITS-1:0] o_read_register_1;
    logic [REG_ADDRS_BITS-1:0] o_read_register_2;
    logic                      o_stall;
    logic                      o_ex_valid;
    logic [31:0]               o_ex_pc_next;
    logic [PROC_BITS-1:0]      o_ex_data_1;
    logic [PROC_BITS-1:0]      o_ex_data_2;
    logic [PROC_BITS-1:0]      o_ex_imm;
    logic [REG_ADDRS_BITS-1:0] o_ex_rs;
    logic [REG_ADDRS_BITS-1:0] o_ex_rt;
    logic [REG_ADDRS_BITS-1:0] o_ex_rd;
    logic [4:0]                o_ex_shamt;
    logic [CTRL_BITS-1:0]      o_ex_ctrl;

    modport slave (
        input  i_enable, i_valid, i_instruction, i_pc_next, i_ctrl,
               i_read_data_1, i_read_data_2, i_flush,
        output o_read_register_1, o_read_register_2, o_stall, o_ex_valid,
               o_ex_pc_next, o_ex_data_1, o_ex_data_2, o_ex_imm,
               o_ex_rs, o_ex_rt, o_ex_rd, o_ex_shamt, o_ex_ctrl
    );

    modport master (
        output i_enable, i_valid, i_instruction, i_pc_next, i_ctrl,
               i_read_data_1, i_read_data_2, i_flush,
        input  o_read_register_1, o_read_register_2, o_stall, o_ex_valid,
               o_ex_pc_next, o_ex_data_1, o_ex_data_2, o_ex_imm,
               o_ex_rs, o_ex_rt, o_ex_rd, o_ex_shamt, o_ex_ctrl
    );
endinterface

// File: rtl/id_ex_stage_hazard_detector.sv
// Load-use hazard term and the RUN/STALL register that limits each hazard to one bubble.
//   state    | meaning
//   ID_RUN   | normal issue; a load-use hazard raises stall and inserts a bubble
//   ID_STALL | bubble is in EX, load result now forwardable; issue normally
module id_ex_stage_hazard_detector
    import id_ex_stage_pkg::*;
#(
    parameter int REG_ADDRS_BITS = DEF_REG_ADDRS_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      flush,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDRS_BITS-1:0] ex_rt,
    input  logic                      id_valid,
    input  logic [REG_ADDRS_BITS-1:0] id_rs,
    input  logic [REG_ADDRS_BITS-1:0] id_rt,
    input  logic                      id_uses_rt,
    output logic                      stall
);
    id_state_e state;
    logic      hazard;

    always_comb begin
        hazard = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || ((ex_rt == id_rt) && id_uses_rt));
        stall  = enable && (state == ID_RUN) && hazard && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ID_RUN;
        end else if (enable) begin
            if (flush)
                state <= ID_RUN;
            else if ((state == ID_RUN) && hazard)
                state <= ID_STALL;
            else
                state <= ID_RUN;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: latches operands, immediate and control, inserts load-use bubbles.
// Load-use stalling is built only when ID_EX_LOAD_USE_STALL_EN is defined.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int PROC_BITS      = DEF_PROC_BITS,
    parameter int REG_ADDRS_BITS = DEF_REG_ADDRS_BITS,
    parameter int CTRL_BITS      = DEF_CTRL_BITS
) (
    input  logic          clk,
    input  logic          i_rst_n,
    id_ex_stage_if.slave  bus
);
    logic [15:0]               imm_field;
    logic [PROC_BITS-1:0]      imm_ext;
    logic                      stall;
    logic                      bubble;
    logic                      ex_valid;
    logic [31:0]               ex_pc_next;
    logic [PROC_BITS-1:0]      ex_data_1;
    logic [PROC_BITS-1:0]      ex_data_2;
    logic [PROC_BITS-1:0]      ex_imm;
    logic [REG_ADDRS_BITS-1:0] ex_rs;
    logic [REG_ADDRS_BITS-1:0] ex_rt;
    logic [REG_ADDRS_BITS-1:0] ex_rd;
    logic [4:0]                ex_shamt;
    logic [CTRL_BITS-1:0]      ex_ctrl;
    logic                      unused_opcode;

    assign imm_field     = bus.i_instruction[15:0];
    assign unused_opcode = ^bus.i_instruction[31:26];

    always_comb begin
        if (bus.i_ctrl[CTRL_IMM_ZEXT])
            imm_ext = {{(PROC_BITS-16){1'b0}}, imm_field};
        else
            imm_ext = {{(PROC_BITS-16){imm_field[15]}}, imm_field};
    end

    assign bus.o_read_register_1 = bus.i_instruction[25:21];
    assign bus.o_read_register_2 = bus.i_instruction[20:16];

`ifdef ID_EX_LOAD_USE_STALL_EN
    id_ex_stage_hazard_detector #(
        .REG_ADDRS_BITS (REG_ADDRS_BITS)
    ) u_hazard (
        .clk         (clk),
        .rst_n       (i_rst_n),
        .enable      (bus.i_enable),
        .flush       (bus.i_flush),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
        .ex_rt       (ex_rt),
        .id_valid    (bus.i_valid),
        .id_rs       (bus.i_instruction[25:21]),
        .id_rt       (bus.i_instruction[20:16]),
        .id_uses_rt  (bus.i_ctrl[CTRL_USES_RT]),
        .stall       (stall)
    );
`else
    // Without interlock the toolchain is responsible for load-delay NOPs.
    assign stall = 1'b0;
`endif

    assign bubble = bus.i_flush || stall;

    // Datapath fields follow the inputs even on a bubble; only valid/ctrl mark it dead.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc_next <= '0;
            ex_data_1  <= '0;
            ex_data_2  <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_shamt   <= '0;
            ex_ctrl    <= '0;
        end else if (bus.i_enable) begin
            ex_pc_next <= bus.i_pc_next;
            ex_data_1  <= bus.i_read_data_1;
            ex_data_2  <= bus.i_read_data_2;
            ex_imm     <= imm_ext;
            ex_rs      <= bus.i_instruction[25:21];
            ex_rt      <= bus.i_instruction[20:16];
            ex_rd      <= bus.i_instruction[15:11];
            ex_shamt   <= bus.i_instruction[10:6];
            if (bubble) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
            end else begin
                ex_valid <= bus.i_valid;
                ex_ctrl  <= bus.i_valid ? bus.i_ctrl : '0;
            end
        end
    end

    assign bus.o_stall      = stall;
    assign bus.o_ex_valid   = ex_valid;
    assign bus.o_ex_pc_next = ex_pc_next;
    assign bus.o_ex_data_1  = ex_data_1;
    assign bus.o_ex_data_2  = ex_data_2;
    assign bus.o_ex_imm     = ex_imm;
    assign bus.o_ex_rs      = ex_rs;
    assign bus.o_ex_rt      = ex_rt;
    assign bus.o_ex_rd      = ex_rd;
    assign bus.o_ex_shamt   = ex_shamt;
    assign bus.o_ex_ctrl    = ex_ctrl;
endmodule
